// File: rtl/decode_bcd_seq.sv
// Sequential binary-to-BCD (double-dabble) converter driving active-low
// seven-segment digits, with saturation, leading-zero blanking and enable.
module decode_bcd_seq #(
  parameter int WIDTH       = 14,
  parameter int DIGITS      = 4,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      X,
  input  logic                  EN,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int          BW      = 4 * DIGITS;
  localparam int          CW      = $clog2(WIDTH + 1);
  localparam logic [31:0] MAX_VAL = 32'((10 ** DIGITS) - 1);
  localparam logic [6:0]  GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [BW-1:0]        digits_q, digits_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;
  logic [7*DIGITS-1:0]  seg_q, seg_d;

  logic [BW-1:0]        bcd_adj;
  logic [BW-1:0]        nines;
  logic [31:0]          x_ext;
  logic                 nonzero_seen;
  logic [3:0]           dig;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0000100;
      default: glyph = GLYPH_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    if (n >= 4'd5) begin
      add3 = n + 4'd3;
    end else begin
      add3 = n;
    end
  endfunction

  assign x_ext = {{(32-WIDTH){1'b0}}, X};

  // Per-nibble add-3 correction applied before each shift
  always_comb begin
    bcd_adj = '0;
    nines   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
      nines[4*i +: 4]   = 4'd9;
    end
  end

  // Conversion sequencer: next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d      = X;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (x_ext > MAX_VAL);
          state_d    = S_CONV;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_CONV: begin
        // Bits carried out of the top nibble are dropped; overflow covers them
        bcd_d = (bcd_adj << 1) | BW'(bin_q[WIDTH-1]);
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_CONV;
        end
      end
      S_LOAD: begin
        digits_d   = ovf_pend_q ? nines : bcd_q;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Display slices from stored digits, scanning from the most significant down
  always_comb begin
    seg_d        = '1;
    nonzero_seen = 1'b0;
    dig          = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig = digits_q[4*i +: 4];
      if (dig != 4'd0) begin
        nonzero_seen = 1'b1;
      end else begin
        nonzero_seen = nonzero_seen;
      end
      if (!EN) begin
        seg_d[7*i +: 7] = GLYPH_BLANK;
      end else if (overflow_q) begin
        seg_d[7*i +: 7] = glyph(4'd9);
      end else if (BLANK_ZEROS && (i > 0) && !nonzero_seen) begin
        seg_d[7*i +: 7] = GLYPH_BLANK;
      end else begin
        seg_d[7*i +: 7] = glyph(dig);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      seg_q      <= '1;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      seg_q      <= seg_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_decode_bcd_seq.sv
// Scoreboard bench for decode_bcd_seq: three instances cover the default
// configuration, leading zeros shown, and the 20-bit / 6-digit variant.
module tb_decode_bcd_seq;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] G9 = 7'b0000100;
  localparam logic [6:0] GB = 7'b1111111;

  typedef struct packed {
    logic [41:0] seg;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  start_v;
  logic [19:0] x_v [3];
  logic [2:0]  done_v, busy_v, ovf_v;
  logic [27:0] seg_a, seg_b;
  logic [41:0] seg_c;
  logic [41:0] seg_v [3];

  exp_t q0[$], q1[$], q2[$];
  exp_t hold [3];
  logic [2:0] pend = 3'b000;
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  decode_bcd_seq #(.WIDTH(14), .DIGITS(4), .BLANK_ZEROS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .X(x_v[0][13:0]), .EN(en),
    .busy(busy_v[0]), .done(done_v[0]), .overflow(ovf_v[0]), .seg(seg_a));

  decode_bcd_seq #(.WIDTH(14), .DIGITS(4), .BLANK_ZEROS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .X(x_v[1][13:0]), .EN(en),
    .busy(busy_v[1]), .done(done_v[1]), .overflow(ovf_v[1]), .seg(seg_b));

  decode_bcd_seq #(.WIDTH(20), .DIGITS(6), .BLANK_ZEROS(1'b1)) dut_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .X(x_v[2]), .EN(en),
    .busy(busy_v[2]), .done(done_v[2]), .overflow(ovf_v[2]), .seg(seg_c));

  assign seg_v[0] = {14'd0, seg_a};
  assign seg_v[1] = {14'd0, seg_b};
  assign seg_v[2] = seg_c;

  task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: overflow checked on done, segments one cycle later
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pend[i]) begin
        chk($sformatf("seg_dut%0d", i), seg_v[i], hold[i].seg);
        pend[i] = 1'b0;
      end
      if (done_v[i] === 1'b1) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0) ||
            (i == 2 && q2.size() == 0)) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_done_dut%0d: got done=1 expected no done", i);
        end else begin
          case (i)
            0:       hold[i] = q0.pop_front();
            1:       hold[i] = q1.pop_front();
            default: hold[i] = q2.pop_front();
          endcase
          chk($sformatf("overflow_dut%0d", i), {41'd0, ovf_v[i]}, {41'd0, hold[i].ovf});
          pend[i] = 1'b1;
        end
      end
    end
  end

  task automatic run(input int sel, input logic [19:0] x, input logic [41:0] eseg,
                     input logic eovf, input int w, input bit extra);
    exp_t e;
    int   cnt;
    bit   got;
    e.seg = eseg;
    e.ovf = eovf;
    case (sel)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(negedge clk);
    x_v[sel]     = x;
    start_v[sel] = 1'b1;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        start_v[sel] = 1'b0;
        x_v[sel]     = 20'hABCDE;
      end
      if (extra && (cnt == 4 || cnt == 8)) start_v[sel] = 1'b1;
      if (extra && (cnt == 5 || cnt == 9)) start_v[sel] = 1'b0;
      if (cnt == 2) chk("busy_during_conv", {41'd0, busy_v[sel]}, 42'd1);
      if (done_v[sel] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout_dut%0d: got no done in 60 cycles expected done", sel);
    end else begin
      chk("done_latency", 42'(cnt), 42'(w + 2));
      chk("busy_at_done", {41'd0, busy_v[sel]}, 42'd0);
    end
    repeat (extra ? 30 : 2) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b1;
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) x_v[i] = 20'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_seg_dut%0d", i), seg_v[i], (i == 2) ? {42{1'b1}} : {14'd0, {28{1'b1}}});
    end
    chk("reset_flags", {33'd0, busy_v, done_v, ovf_v}, 42'd0);
    reset = 1'b0;

    run(0, 20'd373,   {14'd0, GB, G3, G7, G3}, 1'b0, 14, 1'b0);
    run(0, 20'd1005,  {14'd0, G1, G0, G0, G5}, 1'b0, 14, 1'b0);
    run(0, 20'd0,     {14'd0, GB, GB, GB, G0}, 1'b0, 14, 1'b0);
    run(0, 20'd50,    {14'd0, GB, GB, G5, G0}, 1'b0, 14, 1'b0);
    run(0, 20'd9999,  {14'd0, G9, G9, G9, G9}, 1'b0, 14, 1'b0);
    run(0, 20'd12000, {14'd0, G9, G9, G9, G9}, 1'b1, 14, 1'b0);
    run(0, 20'd1234,  {14'd0, G1, G2, G3, G4}, 1'b0, 14, 1'b1);

    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en_off_blank", seg_v[0], {14'd0, {28{1'b1}}});
    end
    en = 1'b1;
    @(negedge clk);
    chk("en_restore", seg_v[0], {14'd0, G1, G2, G3, G4});

    run(0, 20'd16383, {14'd0, G9, G9, G9, G9}, 1'b1, 14, 1'b0);
    @(negedge clk);
    x_v[0]     = 20'd500;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midconv_reset_seg", seg_v[0], {14'd0, {28{1'b1}}});
    chk("midconv_reset_flags", {39'd0, busy_v[0], done_v[0], ovf_v[0]}, 42'd0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    chk("midconv_reset_idle", {41'd0, busy_v[0]}, 42'd0);

    run(1, 20'd0,    {14'd0, G0, G0, G0, G0}, 1'b0, 14, 1'b0);
    run(1, 20'd42,   {14'd0, G0, G0, G4, G2}, 1'b0, 14, 1'b0);
    run(1, 20'd1005, {14'd0, G1, G0, G0, G5}, 1'b0, 14, 1'b0);

    run(2, 20'd999999,  {G9, G9, G9, G9, G9, G9}, 1'b0, 20, 1'b0);
    run(2, 20'd100200,  {G1, G0, G0, G2, G0, G0}, 1'b0, 20, 1'b0);
    run(2, 20'd1000000, {G9, G9, G9, G9, G9, G9}, 1'b1, 20, 1'b0);
    run(2, 20'd7,       {GB, GB, GB, GB, GB, G7}, 1'b0, 20, 1'b0);

    chk("queue0_drained", 42'(q0.size()), 42'd0);
    chk("queue1_drained", 42'(q1.size()), 42'd0);
    chk("queue2_drained", 42'(q2.size()), 42'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
